// File: rtl/pipe_stage_reg.sv
// Pipeline stage boundary register with valid/ready handshake, optional
// two-entry skid buffer, synchronous flush and a saturating stall counter.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_EMPTY   | nothing held, out_valid_o low, upstream may send
// ST_FULL    | main register holds the entry presented downstream
// ST_SKIDDED | main plus skid held (SKID=1 only), upstream is blocked
module pipe_stage_reg #(
   parameter int DATA_W = 96,
   parameter int CTRL_W = 8,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [CTRL_W-1:0] in_ctrl_i,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [CTRL_W-1:0] out_ctrl_o,
   output logic [DATA_W-1:0] out_data_o,
   output logic [CNT_W-1:0]  stall_cnt_o,
   input  logic              stall_cnt_clr_i
);

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_FULL    = 2'd1,
      ST_SKIDDED = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [CTRL_W-1:0]   r_main_ctrl;
   logic [DATA_W-1:0]   r_main_data;
   logic [CTRL_W-1:0]   r_skid_ctrl;
   logic [DATA_W-1:0]   r_skid_data;
   logic                r_in_ready;
   logic [CNT_W-1:0]    r_stall_cnt;

   logic                w_accept;
   logic                w_drain;
   logic                w_load_main_in;
   logic                w_load_main_skid;
   logic                w_load_skid;
   logic                w_in_ready_nxt;
   logic                w_stall;
   logic                w_cnt_sat;

   assign out_valid_o = (r_state != ST_EMPTY);
   // With the skid buffer upstream ready comes straight from a flop, which
   // breaks the combinational ready path through this stage.
   assign in_ready_o  = (SKID != 0) ? r_in_ready : (!out_valid_o | out_ready_i);
   assign w_accept    = in_valid_i & in_ready_o;
   assign w_drain     = out_valid_o & out_ready_i;

   // Bubbles must never carry live control bits such as RegWrite/MemWrite.
   assign out_ctrl_o  = r_main_ctrl & {CTRL_W{out_valid_o}};
   assign out_data_o  = r_main_data;
   assign stall_cnt_o = r_stall_cnt;

   assign w_stall     = out_valid_o & !out_ready_i;
   assign w_cnt_sat   = (r_stall_cnt == {CNT_W{1'b1}});

   // Next state and register load enables; flush overrides everything.
   always_comb begin
      w_state_nxt      = r_state;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (w_accept) begin
               w_load_main_in = 1'b1;
               w_state_nxt    = ST_FULL;
            end
         end
         ST_FULL: begin
            if (w_accept && w_drain) begin
               w_load_main_in = 1'b1;
            end else if (w_accept) begin
               // Only reachable with the skid buffer: the combinational ready
               // of the single-entry variant forbids accept without drain here.
               if (SKID != 0) begin
                  w_load_skid = 1'b1;
                  w_state_nxt = ST_SKIDDED;
               end else begin
                  w_load_main_in = 1'b1;
               end
            end else if (w_drain) begin
               w_state_nxt = ST_EMPTY;
            end
         end
         ST_SKIDDED: begin
            if (w_drain) begin
               w_load_main_skid = 1'b1;
               w_state_nxt      = ST_FULL;
            end
         end
         default: begin
            w_state_nxt = ST_EMPTY;
         end
      endcase
      // Handshakes in the flush cycle still complete, but whatever was taken
      // is dropped and the data registers keep their previous contents.
      if (flush_i) begin
         w_state_nxt      = ST_EMPTY;
         w_load_main_in   = 1'b0;
         w_load_main_skid = 1'b0;
         w_load_skid      = 1'b0;
      end
      w_in_ready_nxt = (w_state_nxt != ST_SKIDDED);
   end

   // State register and registered upstream ready.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state    <= ST_EMPTY;
         r_in_ready <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_in_ready <= w_in_ready_nxt;
      end
   end

   // Main register: loaded from upstream or promoted from the skid entry.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_main_ctrl <= '0;
         r_main_data <= '0;
      end else if (w_load_main_in) begin
         r_main_ctrl <= in_ctrl_i;
         r_main_data <= in_data_i;
      end else if (w_load_main_skid) begin
         r_main_ctrl <= r_skid_ctrl;
         r_main_data <= r_skid_data;
      end
   end

   // Skid register catches the entry accepted in the cycle ready dropped.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_skid_ctrl <= '0;
         r_skid_data <= '0;
      end else if (w_load_skid) begin
         r_skid_ctrl <= in_ctrl_i;
         r_skid_data <= in_data_i;
      end
   end

   // Saturating stall counter; clear wins over increment, flush is ignored.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_stall_cnt <= '0;
      end else if (stall_cnt_clr_i) begin
         r_stall_cnt <= '0;
      end else if (w_stall && !w_cnt_sat) begin
         r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one SKID=0 and one SKID=1 instance, each with a
// scoreboard queue, a cycle table for the skid fill/drain sequence and
// hand-written sequences for reset, flush and counter saturation.
module tb_pipe_stage_reg;
   localparam int DW = 96;
   localparam int CW = 8;
   localparam int NW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush     [2];
   logic          in_valid  [2];
   logic          in_ready  [2];
   logic [CW-1:0] in_ctrl   [2];
   logic [DW-1:0] in_data   [2];
   logic          out_valid [2];
   logic          out_ready [2];
   logic [CW-1:0] out_ctrl  [2];
   logic [DW-1:0] out_data  [2];
   logic [NW-1:0] stall     [2];
   logic          clr       [2];

   typedef struct packed {
      logic [CW-1:0] c;
      logic [DW-1:0] d;
   } ent_t;

   typedef struct {
      logic          iv;
      logic [DW-1:0] din;
      logic          ordy;
      logic          exp_ov;
      logic          exp_ir;
      logic [DW-1:0] exp_d;
      logic [NW-1:0] exp_st;
   } vec_t;

   ent_t q0[$];
   ent_t q1[$];
   int   total = 0;
   int   bad   = 0;
   int   ndrain [2];
   vec_t tbl [8];

   always #5 clk = ~clk;

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(NW)) u_dut0 (
      .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush[0]),
      .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
      .in_ctrl_i(in_ctrl[0]), .in_data_i(in_data[0]),
      .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]),
      .out_ctrl_o(out_ctrl[0]), .out_data_o(out_data[0]),
      .stall_cnt_o(stall[0]), .stall_cnt_clr_i(clr[0]));

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(NW)) u_dut1 (
      .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush[1]),
      .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
      .in_ctrl_i(in_ctrl[1]), .in_data_i(in_data[1]),
      .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]),
      .out_ctrl_o(out_ctrl[1]), .out_data_o(out_data[1]),
      .stall_cnt_o(stall[1]), .stall_cnt_clr_i(clr[1]));

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input int d, input logic v, input logic [DW-1:0] data,
                        input logic [CW-1:0] ctrl, input logic ordy);
      in_valid[d]  = v;
      in_data[d]   = data;
      in_ctrl[d]   = ctrl;
      out_ready[d] = ordy;
   endtask

   // Called at a falling edge with inputs set: records handshakes for the
   // coming rising edge in the scoreboards, then steps to the next falling edge.
   task automatic tick();
      ent_t e;
      logic acc;
      logic drn;
      int   sz;
      #1;
      for (int d = 0; d < 2; d++) begin
         acc = in_valid[d] & in_ready[d];
         drn = out_valid[d] & out_ready[d];
         if (!out_valid[d]) chk($sformatf("ctrl_bubble%0d", d), out_ctrl[d], 0);
         if (drn) begin
            ndrain[d]++;
            sz = (d == 0) ? q0.size() : q1.size();
            if (sz == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_out%0d: got %0h want no entry", d, out_data[d]);
            end else begin
               if (d == 0) e = q0.pop_front();
               else        e = q1.pop_front();
               chk($sformatf("sb_data%0d", d), out_data[d], e.d);
               chk($sformatf("sb_ctrl%0d", d), out_ctrl[d], e.c);
            end
         end
         if (flush[d]) begin
            if (d == 0) q0.delete();
            else        q1.delete();
         end else if (acc) begin
            e.c = in_ctrl[d];
            e.d = in_data[d];
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
         end
      end
      @(negedge clk);
   endtask

   task automatic clear_cnt(input int d);
      clr[d] = 1'b1;
      tick();
      clr[d] = 1'b0;
   endtask

   task automatic stream(input int d);
      int n0;
      clear_cnt(d);
      n0 = ndrain[d];
      for (int i = 1; i <= 8; i++) begin
         drive(d, 1'b1, DW'(i), 8'hFF, 1'b1);
         tick();
         chk($sformatf("stream_valid%0d", d), out_valid[d], 1);
         chk($sformatf("stream_lat%0d", d), out_data[d], i);
      end
      drive(d, 1'b0, '0, '0, 1'b1);
      tick();
      tick();
      chk($sformatf("stream_cnt%0d", d), ndrain[d] - n0, 8);
      chk($sformatf("stream_stall%0d", d), stall[d], 0);
   endtask

   // Upstream holds each value until accepted; downstream stalls cycles 1..3.
   task automatic backpressure(input int d);
      int  k;
      int  n0;
      logic acc;
      clear_cnt(d);
      n0 = ndrain[d];
      k  = 1;
      for (int cyc = 0; cyc < 12; cyc++) begin
         drive(d, (k <= 3), DW'(k), 8'h0F, !(cyc >= 1 && cyc <= 3));
         #1;
         acc = in_valid[d] & in_ready[d];
         tick();
         if (acc) k++;
      end
      drive(d, 1'b0, '0, '0, 1'b1);
      tick();
      chk($sformatf("bp_cnt%0d", d), ndrain[d] - n0, 3);
      chk($sformatf("bp_stall%0d", d), stall[d], 3);
   endtask

   initial begin
      tbl[0] = '{1'b1, 96'd1, 1'b1, 1'b0, 1'b1, 96'd0, 4'd0};
      tbl[1] = '{1'b1, 96'd2, 1'b0, 1'b1, 1'b1, 96'd1, 4'd0};
      tbl[2] = '{1'b1, 96'd3, 1'b0, 1'b1, 1'b0, 96'd1, 4'd1};
      tbl[3] = '{1'b1, 96'd3, 1'b0, 1'b1, 1'b0, 96'd1, 4'd2};
      tbl[4] = '{1'b1, 96'd3, 1'b1, 1'b1, 1'b0, 96'd1, 4'd3};
      tbl[5] = '{1'b1, 96'd3, 1'b1, 1'b1, 1'b1, 96'd2, 4'd3};
      tbl[6] = '{1'b0, 96'd0, 1'b1, 1'b1, 1'b1, 96'd3, 4'd3};
      tbl[7] = '{1'b0, 96'd0, 1'b1, 1'b0, 1'b1, 96'd0, 4'd3};

      for (int d = 0; d < 2; d++) begin
         flush[d] = 1'b0;
         clr[d]   = 1'b0;
         ndrain[d] = 0;
         drive(d, 1'b0, '0, '0, 1'b0);
      end
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst_valid%0d", d), out_valid[d], 0);
         chk($sformatf("rst_ctrl%0d", d), out_ctrl[d], 0);
         chk($sformatf("rst_data%0d", d), out_data[d], 0);
         chk($sformatf("rst_ready%0d", d), in_ready[d], 1);
         chk($sformatf("rst_stall%0d", d), stall[d], 0);
      end
      rst_n = 1'b1;
      @(negedge clk);

      stream(0);
      stream(1);
      backpressure(0);
      backpressure(1);

      // SKID=0: ready follows out_ready combinationally while full.
      drive(0, 1'b1, 96'h55, 8'h11, 1'b1);
      tick();
      drive(0, 1'b0, '0, '0, 1'b0);
      #1 chk("comb_ready_lo", in_ready[0], 0);
      out_ready[0] = 1'b1;
      #1 chk("comb_ready_hi", in_ready[0], 1);
      tick();

      // SKID=1 fill/drain, one table row per cycle, checked before each edge.
      drive(1, 1'b0, '0, '0, 1'b1);
      clear_cnt(1);
      for (int i = 0; i < 8; i++) begin
         drive(1, tbl[i].iv, tbl[i].din, 8'h5A, tbl[i].ordy);
         #1;
         chk($sformatf("tbl%0d_valid", i), out_valid[1], tbl[i].exp_ov);
         chk($sformatf("tbl%0d_ready", i), in_ready[1], tbl[i].exp_ir);
         chk($sformatf("tbl%0d_stall", i), stall[1], tbl[i].exp_st);
         if (tbl[i].exp_ov) chk($sformatf("tbl%0d_data", i), out_data[1], tbl[i].exp_d);
         tick();
      end

      // Flush while skidded: everything held is dropped, 0x7 never shows.
      drive(1, 1'b1, 96'h11, 8'h3C, 1'b1);
      tick();
      drive(1, 1'b1, 96'h22, 8'h3C, 1'b0);
      tick();
      chk("skidded_ready", in_ready[1], 0);
      flush[1] = 1'b1;
      drive(1, 1'b1, 96'h7, 8'hC3, 1'b0);
      tick();
      flush[1] = 1'b0;
      drive(1, 1'b0, '0, '0, 1'b0);
      #1;
      chk("flush_valid", out_valid[1], 0);
      chk("flush_ctrl", out_ctrl[1], 0);
      chk("flush_ready", in_ready[1], 1);
      chk("flush_data_kept", out_data[1], 96'h11);
      out_ready[1] = 1'b1;
      tick();
      tick();
      drive(1, 1'b1, 96'h33, 8'h3C, 1'b1);
      tick();
      chk("post_flush_data", out_data[1], 96'h33);
      drive(1, 1'b0, '0, '0, 1'b1);
      tick();

      // Saturation at 15, then clear during a stall gives 0 followed by 1.
      clear_cnt(1);
      drive(1, 1'b1, 96'h44, 8'h01, 1'b0);
      tick();
      drive(1, 1'b0, '0, '0, 1'b0);
      repeat (20) tick();
      chk("sat_15", stall[1], 15);
      clr[1] = 1'b1;
      tick();
      chk("clr_zero", stall[1], 0);
      clr[1] = 1'b0;
      tick();
      chk("clr_then_one", stall[1], 1);
      out_ready[1] = 1'b1;
      tick();

      // Asynchronous reset between edges while skidded with 0xA/0xB.
      drive(1, 1'b1, 96'hA, 8'h77, 1'b1);
      tick();
      drive(1, 1'b1, 96'hB, 8'h77, 1'b0);
      tick();
      drive(1, 1'b0, '0, '0, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_valid", out_valid[1], 0);
      chk("midrst_ctrl", out_ctrl[1], 0);
      chk("midrst_data", out_data[1], 0);
      chk("midrst_ready", in_ready[1], 1);
      chk("midrst_stall", stall[1], 0);
      #2 rst_n = 1'b1;
      q0.delete();
      q1.delete();
      @(negedge clk);
      drive(1, 1'b1, 96'hC, 8'h21, 1'b1);
      tick();
      chk("postrst_valid", out_valid[1], 1);
      chk("postrst_data", out_data[1], 96'hC);
      drive(1, 1'b0, '0, '0, 1'b1);
      tick();
      tick();

      chk("sb_empty", q0.size() + q1.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register, the generalised successor to the fixed per-stage latches between ID/EX/MEM/WB. It carries a control field and a data field of configurable width through one pipeline boundary, with a valid/ready handshake, an optional 2-entry skid buffer that fully registers upstream ready, synchronous flush with bubble insertion, and a saturating stall-cycle counter. One instance is placed at each stage boundary of the 5-stage core.

## Interface
- `DATA_W`, default 96, data payload width (e.g. RS, RT and SignExtend, 32 b each).
- `CTRL_W`, default 8, control payload width; these bits are forced to 0 whenever the output is not valid.
- `SKID`, default 1. 1 = 2-entry skid buffer with registered `in_ready_o`; 0 = single entry with combinational `in_ready_o`.
- `CNT_W`, default 16, stall counter width.

Ports:
- `clk_i` input 1: the single clock, all state updates on its rising edge.
- `rst_n_i` input 1: reset, asynchronous and active-low.
- `flush_i` input 1: synchronous kill of all held entries.
- `in_valid_i` input 1: upstream entry present.
- `in_ready_o` output 1: stage can accept.
- `in_ctrl_i` input CTRL_W: upstream control bits.
- `in_data_i` input DATA_W: upstream data.
- `out_valid_o` output 1: entry presented downstream.
- `out_ready_i` input 1: downstream accepts.
- `out_ctrl_o` output CTRL_W: main control register, ANDed with `out_valid_o`.
- `out_data_o` output DATA_W: main data register, unmasked.
- `stall_cnt_o` output CNT_W: saturating count of stalled cycles.
- `stall_cnt_clr_i` input 1: synchronous clear of `stall_cnt_o`.

## Operation
- Definitions: accept = `in_valid_i` & `in_ready_o`; drain = `out_valid_o` & `out_ready_i`.
- States (SKID=1): EMPTY, FULL (main only), SKIDDED (main + skid). `out_valid_o` = (state != EMPTY). `in_ready_o` is a flop: 1 in EMPTY and FULL, 0 in SKIDDED.
- Transitions from EMPTY:
  - On accept: main <= in, go to FULL.
- Transitions from FULL:
  - accept & drain: main <= in, stay in FULL.
  - accept & !drain: skid <= in, go to SKIDDED.
  - !accept & drain: go to EMPTY.
  - Neither: hold.
- Transitions from SKIDDED:
  - On drain: main <= skid, go to FULL.
  - Otherwise: hold. No accept is possible in this state.
- SKID=0:
  - States are EMPTY and FULL only.
  - `in_ready_o` = !`out_valid_o` | `out_ready_i`, combinational.
  - accept loads main. drain without accept goes to EMPTY.
- Flush (`flush_i`=1) has highest priority:
  - Next state is EMPTY and `in_ready_o` is 1 the next cycle.
  - An accept or drain in the flush cycle is still a valid handshake on that edge, but the accepted entry is discarded.
  - Data registers keep their old values; the control field is masked by the now-low valid.
- Stall counter:
  - Increments on each cycle with `out_valid_o` & !`out_ready_i`.
  - Saturates at all-ones.
  - `stall_cnt_clr_i` clears it to 0 and takes priority over increment.
  - Flush does not affect it.

## Timing
- Reset (`rst_n_i`=0, asynchronous, at any time including mid-transfer) sets:
  - State EMPTY.
  - `out_valid_o`=0, `out_ctrl_o`=0, `out_data_o`=0.
  - Skid registers 0.
  - `in_ready_o`=1.
  - `stall_cnt_o`=0.
- Latency: an entry accepted at edge N appears on `out_*` after edge N (1 cycle).
- Throughput: 1 entry/cycle while `out_ready_i`=1, for both SKID values.
- SKID=1 back-pressure:
  - `out_ready_i` falling at cycle N makes `in_ready_o` low after edge N, if an accept occurred at edge N.
  - The entry accepted at N is held in skid; nothing is lost.
- Ordering: entries leave strictly in acceptance order. The skid entry always follows main.
- `out_ctrl_o` is 0 in every cycle where `out_valid_o`=0, so a bubble never carries RegWrite or MemWrite.

## Test plan
- **Reset mid-stream:** SKIDDED with main=0xA, skid=0xB, then `rst_n_i` low for 3 ns between edges. Outputs go to 0 immediately, `in_ready_o`=1, and the first post-reset accept of 0xC appears after 1 edge.
- **Streaming:** `out_ready_i`=1, send data 1..8 with ctrl=0xFF on consecutive cycles. `out_data_o` shows 1..8 one cycle later, no gaps, `stall_cnt_o`=0.
- **Skid fill/drain (SKID=1):** send 1,2,3 with `out_ready_i`=0 from the cycle after 1 is accepted. 2 is captured in skid, `in_ready_o`=0, 3 is held upstream. Raising `out_ready_i` then yields 1,2,3 in order with no duplicates, and `stall_cnt_o` equals the number of stalled cycles.
- **Flush:** in SKIDDED, assert `flush_i` together with `in_valid_i`=1 and data 0x7. Next cycle `out_valid_o`=0, `out_ctrl_o`=0, `in_ready_o`=1, and 0x7 never appears.
- **Saturation:** CNT_W=4, stall 20 cycles. `stall_cnt_o`=15. Then `stall_cnt_clr_i` pulse during a further stall gives 0, then 1 on the next cycle.
- **SKID=0 equivalence:** repeat the streaming and back-pressure sequences. Output order and data match SKID=1, with `in_ready_o` following `out_ready_i` combinationally when FULL.
